// File: rtl/sprite_renderer_pkg.sv
// rtl/sprite_renderer_pkg.sv - Shared sprite geometry and bitmap images for the dino game renderer
// Purpose: screen placement constants, bitmap sizes/centres, derived widths and ROM images.
// Ports:   none (package).
package sprite_renderer_pkg;

  localparam int DINO_SCREEN_X   = 40;
  localparam int GROUND_SCREEN_Y = 200;

  localparam int DINO_BITMAP_SIZE_X   = 8;
  localparam int DINO_BITMAP_SIZE_Y   = 8;
  localparam int DINO_BITMAP_CENTER_X = 4;
  localparam int DINO_BITMAP_CENTER_Y = 4;
  localparam int DINO_FRAMES          = 4;

  localparam int OBSTACLE_BITMAP_SIZE_X   = 8;
  localparam int OBSTACLE_BITMAP_SIZE_Y   = 8;
  localparam int OBSTACLE_BITMAP_CENTER_X = 4;
  localparam int OBSTACLE_BITMAP_CENTER_Y = 4;

  localparam int DINO_IMG_BITS     = DINO_FRAMES * DINO_BITMAP_SIZE_X * DINO_BITMAP_SIZE_Y;
  localparam int OBSTACLE_IMG_BITS = OBSTACLE_BITMAP_SIZE_X * OBSTACLE_BITMAP_SIZE_Y;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DINO_REL_X_W = width_of(DINO_BITMAP_SIZE_X);
  localparam int DINO_REL_Y_W = width_of(DINO_BITMAP_SIZE_Y);
  localparam int OBS_REL_X_W  = width_of(OBSTACLE_BITMAP_SIZE_X);
  localparam int OBS_REL_Y_W  = width_of(OBSTACLE_BITMAP_SIZE_Y);
  localparam int DINO_ADDR_W  = width_of(DINO_IMG_BITS);
  localparam int OBS_ADDR_W   = width_of(OBSTACLE_IMG_BITS);

  typedef logic [1:0] dino_state_t;

  // Bit index = frame*SX*SY + row*SX + col; row 0 is the top line, frame 0 in the low 64 bits.
  localparam logic [DINO_IMG_BITS-1:0] DINO_IMG = {
    64'h3C7EFFDBFF7E2418,
    64'h1C3E7F6B7F3E1422,
    64'h3C7EFFDBFF7E4281,
    64'h183C7EFFFF7E3C19
  };

  localparam logic [OBSTACLE_IMG_BITS-1:0] OBSTACLE_IMG = 64'h1818DBDBFF181818;

endpackage

// File: rtl/sprite_renderer_rect.sv
// rtl/sprite_renderer_rect.sv - Registered signed-clipping rectangle test for one sprite (stage S1)
// Purpose: decide whether a screen pixel lies inside a sprite placed by its centre, and
//          produce the pixel's coordinates relative to the sprite's top-left corner.
// Ports:   i_clk, i_rst_n        clock, async active-low reset
//          i_en                  sprite enabled (qualifies o_in_rect)
//          i_cx, i_cy            sprite centre, screen space
//          i_sx, i_sy            downsampled screen pixel
//          o_in_rect             registered inside flag
//          o_rel_x, o_rel_y      registered relative coordinates
module sprite_rect #(
  parameter int COORD_W  = 12,
  parameter int SIZE_X   = 8,
  parameter int SIZE_Y   = 8,
  parameter int CENTER_X = 4,
  parameter int CENTER_Y = 4,
  parameter int REL_X_W  = 3,
  parameter int REL_Y_W  = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  input  logic [COORD_W-1:0] i_sx,
  input  logic [COORD_W-1:0] i_sy,
  output logic               o_in_rect,
  output logic [REL_X_W-1:0] o_rel_x,
  output logic [REL_Y_W-1:0] o_rel_y
);

  localparam int SW = COORD_W + 1;

  // One extra bit lets the top-left corner go negative so sprites clip at the left/top edge.
  logic signed [SW-1:0] w_pos_x, w_pos_y, w_end_x, w_end_y, w_sx, w_sy;
  logic                 w_inside;

  assign w_pos_x  = $signed({1'b0, i_cx}) - SW'(CENTER_X);
  assign w_pos_y  = $signed({1'b0, i_cy}) - SW'(CENTER_Y);
  assign w_end_x  = w_pos_x + SW'(SIZE_X);
  assign w_end_y  = w_pos_y + SW'(SIZE_Y);
  assign w_sx     = $signed({1'b0, i_sx});
  assign w_sy     = $signed({1'b0, i_sy});
  assign w_inside = (w_sx >= w_pos_x) && (w_sx < w_end_x) &&
                    (w_sy >= w_pos_y) && (w_sy < w_end_y);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_in_rect <= 1'b0;
      o_rel_x   <= '0;
      o_rel_y   <= '0;
    end else begin
      o_in_rect <= i_en & w_inside;
      o_rel_x   <= REL_X_W'(w_sx - w_pos_x);
      o_rel_y   <= REL_Y_W'(w_sy - w_pos_y);
    end
  end

endmodule

// File: rtl/sprite_renderer.sv
// rtl/sprite_renderer.sv - Dino + NUM_OBS obstacle sprite compositor with per-frame collision flag
// Purpose: 3-stage pixel pipeline (rect test, bitmap lookup, compose) over frame-latched game state.
// Ports:   i_pixel_clk, i_rst_n          clock, async active-low reset
//          i_frame_start                 first-pixel-of-frame pulse (latches game state)
//          i_de, i_vga_x, i_vga_y        raster position and display enable
//          i_dino_y, i_dino_state        dino vertical centre and animation frame
//          i_obstacle_x, i_obstacle_en   packed obstacle centres and enables
//          i_night                       invert colours
//          o_pixel, o_pixel_de           registered pixel and aligned display enable
//          o_collision                   previous frame had a dino/obstacle overlap
module sprite_renderer
  import sprite_renderer_pkg::*;
#(
  parameter int NUM_OBS     = 3,
  parameter int SCALE_SHIFT = 1,
  parameter int COORD_W     = 12
) (
  input  logic                       i_pixel_clk,
  input  logic                       i_rst_n,
  input  logic                       i_frame_start,
  input  logic                       i_de,
  input  logic [COORD_W-1:0]         i_vga_x,
  input  logic [COORD_W-1:0]         i_vga_y,
  input  logic [COORD_W-1:0]         i_dino_y,
  input  logic [1:0]                 i_dino_state,
  input  logic [NUM_OBS*COORD_W-1:0] i_obstacle_x,
  input  logic [NUM_OBS-1:0]         i_obstacle_en,
  input  logic                       i_night,
  output logic                       o_pixel,
  output logic                       o_pixel_de,
  output logic                       o_collision
);

  // Frame shadow copies; r_armed stays low after reset so nothing draws until a frame starts.
  logic [COORD_W-1:0]         r_dino_y_s;
  dino_state_t                r_dino_state_s;
  logic [NUM_OBS*COORD_W-1:0] r_obs_x_s;
  logic [NUM_OBS-1:0]         r_obs_en_s;
  logic                       r_night_s;
  logic                       r_armed;

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dino_y_s     <= '0;
      r_dino_state_s <= '0;
      r_obs_x_s      <= '0;
      r_obs_en_s     <= '0;
      r_night_s      <= 1'b0;
      r_armed        <= 1'b0;
    end else if (i_frame_start) begin
      r_dino_y_s     <= i_dino_y;
      r_dino_state_s <= i_dino_state;
      r_obs_x_s      <= i_obstacle_x;
      r_obs_en_s     <= i_obstacle_en;
      r_night_s      <= i_night;
      r_armed        <= 1'b1;
    end
  end

  // The first pixel of a frame must already see the values being latched this edge.
  logic [COORD_W-1:0]         w_dino_y;
  dino_state_t                w_dino_state;
  logic [NUM_OBS*COORD_W-1:0] w_obs_x;
  logic [NUM_OBS-1:0]         w_obs_en;
  logic                       w_night, w_armed;
  logic [COORD_W-1:0]         w_sx, w_sy;

  assign w_dino_y     = i_frame_start ? i_dino_y      : r_dino_y_s;
  assign w_dino_state = i_frame_start ? i_dino_state  : r_dino_state_s;
  assign w_obs_x      = i_frame_start ? i_obstacle_x  : r_obs_x_s;
  assign w_obs_en     = i_frame_start ? i_obstacle_en : r_obs_en_s;
  assign w_night      = i_frame_start ? i_night       : r_night_s;
  assign w_armed      = i_frame_start | r_armed;
  assign w_sx         = i_vga_x >> SCALE_SHIFT;
  assign w_sy         = i_vga_y >> SCALE_SHIFT;

  // ---- S1: rect tests (registered inside sprite_rect) plus side-band pipeline ----
  logic                    w_dino_in;
  logic [DINO_REL_X_W-1:0] w_dino_rel_x;
  logic [DINO_REL_Y_W-1:0] w_dino_rel_y;
  logic [NUM_OBS-1:0]      w_obs_in;
  logic [OBS_REL_X_W-1:0]  w_obs_rel_x [NUM_OBS];
  logic [OBS_REL_Y_W-1:0]  w_obs_rel_y [NUM_OBS];
  logic [OBS_ADDR_W-1:0]   w_obs_addr  [NUM_OBS];

  for (genvar g = 0; g <= NUM_OBS; g++) begin : g_rect
    if (g == 0) begin : g_dino
      sprite_rect #(
        .COORD_W (COORD_W),
        .SIZE_X  (DINO_BITMAP_SIZE_X),
        .SIZE_Y  (DINO_BITMAP_SIZE_Y),
        .CENTER_X(DINO_BITMAP_CENTER_X),
        .CENTER_Y(DINO_BITMAP_CENTER_Y),
        .REL_X_W (DINO_REL_X_W),
        .REL_Y_W (DINO_REL_Y_W)
      ) u_rect (
        .i_clk    (i_pixel_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (w_armed),
        .i_cx     (COORD_W'(DINO_SCREEN_X)),
        .i_cy     (w_dino_y),
        .i_sx     (w_sx),
        .i_sy     (w_sy),
        .o_in_rect(w_dino_in),
        .o_rel_x  (w_dino_rel_x),
        .o_rel_y  (w_dino_rel_y)
      );
    end else begin : g_obs
      sprite_rect #(
        .COORD_W (COORD_W),
        .SIZE_X  (OBSTACLE_BITMAP_SIZE_X),
        .SIZE_Y  (OBSTACLE_BITMAP_SIZE_Y),
        .CENTER_X(OBSTACLE_BITMAP_CENTER_X),
        .CENTER_Y(OBSTACLE_BITMAP_CENTER_Y),
        .REL_X_W (OBS_REL_X_W),
        .REL_Y_W (OBS_REL_Y_W)
      ) u_rect (
        .i_clk    (i_pixel_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (w_armed & w_obs_en[g-1]),
        .i_cx     (w_obs_x[(g-1)*COORD_W +: COORD_W]),
        .i_cy     (COORD_W'(GROUND_SCREEN_Y)),
        .i_sx     (w_sx),
        .i_sy     (w_sy),
        .o_in_rect(w_obs_in[g-1]),
        .o_rel_x  (w_obs_rel_x[g-1]),
        .o_rel_y  (w_obs_rel_y[g-1])
      );

      assign w_obs_addr[g-1] = OBS_ADDR_W'(w_obs_rel_y[g-1]) * OBS_ADDR_W'(OBSTACLE_BITMAP_SIZE_X)
                             + OBS_ADDR_W'(w_obs_rel_x[g-1]);
    end
  end

  logic        r_s1_de, r_s1_night;
  dino_state_t r_s1_state;

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_de    <= 1'b0;
      r_s1_night <= 1'b0;
      r_s1_state <= '0;
    end else begin
      r_s1_de    <= i_de;
      r_s1_night <= w_night;
      r_s1_state <= w_dino_state;
    end
  end

  // ---- S2: address calculation and bitmap lookup ----
  logic [DINO_ADDR_W-1:0] w_dino_addr;
  logic                   w_obs_lit;

  assign w_dino_addr = DINO_ADDR_W'(r_s1_state)
                         * DINO_ADDR_W'(DINO_BITMAP_SIZE_X * DINO_BITMAP_SIZE_Y)
                     + DINO_ADDR_W'(w_dino_rel_y) * DINO_ADDR_W'(DINO_BITMAP_SIZE_X)
                     + DINO_ADDR_W'(w_dino_rel_x);

  always_comb begin
    w_obs_lit = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      w_obs_lit = w_obs_lit | (w_obs_in[i] & OBSTACLE_IMG[w_obs_addr[i]]);
    end
  end

  logic r_s2_de, r_s2_night, r_s2_dino_hit, r_s2_obs_hit;

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_de       <= 1'b0;
      r_s2_night    <= 1'b0;
      r_s2_dino_hit <= 1'b0;
      r_s2_obs_hit  <= 1'b0;
    end else begin
      r_s2_de       <= r_s1_de;
      r_s2_night    <= r_s1_night;
      r_s2_dino_hit <= w_dino_in & DINO_IMG[w_dino_addr];
      r_s2_obs_hit  <= w_obs_lit;
    end
  end

  // ---- S3: compose, register outputs, accumulate collisions ----
  logic w_overlap;
  logic r_pixel, r_pixel_de, r_collision, r_acc;

  assign w_overlap = r_s2_de & r_s2_dino_hit & r_s2_obs_hit;

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pixel     <= 1'b0;
      r_pixel_de  <= 1'b0;
      r_collision <= 1'b0;
      r_acc       <= 1'b0;
    end else begin
      r_pixel    <= r_s2_de & (r_s2_night ^ (r_s2_dino_hit | r_s2_obs_hit));
      r_pixel_de <= r_s2_de;
      // The pixel composed on the frame_start cycle still belongs to the closing frame.
      if (i_frame_start) begin
        r_collision <= r_acc | w_overlap;
        r_acc       <= 1'b0;
      end else if (w_overlap) begin
        r_acc <= 1'b1;
      end
    end
  end

  assign o_pixel     = r_pixel;
  assign o_pixel_de  = r_pixel_de;
  assign o_collision = r_collision;

endmodule

// File: tb/tb_sprite_renderer.sv
// tb/tb_sprite_renderer.sv - Self-checking bench for sprite_renderer
module tb_sprite_renderer;
  import sprite_renderer_pkg::*;

  localparam int NUM_OBS     = 3;
  localparam int SCALE_SHIFT = 1;
  localparam int COORD_W     = 12;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       frame_start = 1'b0;
  logic                       de = 1'b0;
  logic [COORD_W-1:0]         vga_x = '0, vga_y = '0, dino_y = '0;
  logic [1:0]                 dino_state = '0;
  logic [NUM_OBS*COORD_W-1:0] obstacle_x = '0;
  logic [NUM_OBS-1:0]         obstacle_en = '0;
  logic                       night = 1'b0;
  logic                       pixel, pixel_de, collision;

  always #5 clk = ~clk;

  sprite_renderer #(.NUM_OBS(NUM_OBS), .SCALE_SHIFT(SCALE_SHIFT), .COORD_W(COORD_W)) dut (
    .i_pixel_clk  (clk),
    .i_rst_n      (rst_n),
    .i_frame_start(frame_start),
    .i_de         (de),
    .i_vga_x      (vga_x),
    .i_vga_y      (vga_y),
    .i_dino_y     (dino_y),
    .i_dino_state (dino_state),
    .i_obstacle_x (obstacle_x),
    .i_obstacle_en(obstacle_en),
    .i_night      (night),
    .o_pixel      (pixel),
    .o_pixel_de   (pixel_de),
    .o_collision  (collision)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DINO_IMG_BITS-1:0]     dimg;
  logic [OBSTACLE_IMG_BITS-1:0] oimg;

  // Reference model: frame-latched game state, expected-output delay line, collision flag.
  int m_dino_y, m_state;
  int m_obs_x [NUM_OBS];
  bit m_en    [NUM_OBS];
  bit m_night, m_armed, m_acc, m_coll;
  bit q_pix[$], q_de[$], q_hit[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit lit_dino(input int sx, input int sy);
    int dx = sx - (DINO_SCREEN_X - DINO_BITMAP_CENTER_X);
    int dy = sy - (m_dino_y - DINO_BITMAP_CENTER_Y);
    if (!m_armed || dx < 0 || dx >= DINO_BITMAP_SIZE_X || dy < 0 || dy >= DINO_BITMAP_SIZE_Y)
      return 1'b0;
    return dimg[m_state*DINO_BITMAP_SIZE_X*DINO_BITMAP_SIZE_Y + dy*DINO_BITMAP_SIZE_X + dx];
  endfunction

  function automatic bit lit_obs(input int i, input int sx, input int sy);
    int dx = sx - (m_obs_x[i] - OBSTACLE_BITMAP_CENTER_X);
    int dy = sy - (GROUND_SCREEN_Y - OBSTACLE_BITMAP_CENTER_Y);
    if (!m_armed || !m_en[i] || dx < 0 || dx >= OBSTACLE_BITMAP_SIZE_X ||
        dy < 0 || dy >= OBSTACLE_BITMAP_SIZE_Y)
      return 1'b0;
    return oimg[dy*OBSTACLE_BITMAP_SIZE_X + dx];
  endfunction

  task automatic model_reset();
    m_dino_y = 0; m_state = 0; m_night = 0; m_armed = 0; m_acc = 0; m_coll = 0;
    for (int i = 0; i < NUM_OBS; i++) begin m_obs_x[i] = 0; m_en[i] = 0; end
    q_pix.delete(); q_de.delete(); q_hit.delete();
    repeat (2) begin q_pix.push_back(0); q_de.push_back(0); q_hit.push_back(0); end
  endtask

  // One pixel clock: drive inputs, predict, clock, compare the pixel that entered two steps ago.
  task automatic step(input int vx, input int vy, input bit d, input bit f);
    bit dh, oh;
    int sx, sy;
    vga_x = COORD_W'(vx); vga_y = COORD_W'(vy); de = d; frame_start = f;
    if (f) begin
      m_dino_y = int'(dino_y); m_state = int'(dino_state); m_night = night; m_armed = 1;
      for (int i = 0; i < NUM_OBS; i++) begin
        m_obs_x[i] = int'(obstacle_x[i*COORD_W +: COORD_W]);
        m_en[i]    = obstacle_en[i];
      end
    end
    sx = vx >> SCALE_SHIFT;
    sy = vy >> SCALE_SHIFT;
    dh = lit_dino(sx, sy);
    oh = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) oh |= lit_obs(i, sx, sy);
    if (f) begin
      m_coll = m_acc | q_hit[0];
      m_acc  = 0;
    end else if (q_hit[0]) begin
      m_acc = 1;
    end
    q_pix.push_back(d & (m_night ^ (dh | oh)));
    q_de.push_back(d);
    q_hit.push_back(d & dh & oh);
    @(posedge clk); #1;
    check("pixel", int'(pixel), int'(q_pix.pop_front()));
    check("pixel_de", int'(pixel_de), int'(q_de.pop_front()));
    void'(q_hit.pop_front());
    check("collision", int'(collision), int'(m_coll));
  endtask

  task automatic probe(input string name, input int vx, input int vy, input bit d, input bit f,
                       input bit exp);
    step(vx, vy, d, f);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check(name, int'(pixel), int'(exp));
  endtask

  task automatic set_obs(input int a, input int b, input int c);
    obstacle_x = {COORD_W'(c), COORD_W'(b), COORD_W'(a)};
  endtask

  typedef struct {
    bit       nt;
    int       state;
    bit [2:0] en;
    int       obs0;
    bit       d;
    int       vx;
    int       vy;
    bit       exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dimg = DINO_IMG;
    oimg = OBSTACLE_IMG;

    repeat (3) @(posedge clk);
    #1;
    check("reset_pixel", int'(pixel), 0);
    check("reset_pixel_de", int'(pixel_de), 0);
    check("reset_collision", int'(collision), 0);
    rst_n = 1'b1;
    model_reset();

    // Probes with hand-derived expectations; dino_y=100, obstacles at 60/120/180.
    tbl.push_back('{0, 0, 3'b101, 60, 1, 72, 192, 1});
    tbl.push_back('{0, 0, 3'b101, 60, 1, 74, 192, 0});
    tbl.push_back('{0, 0, 3'b101, 60, 1, 78, 200, 1});
    tbl.push_back('{0, 0, 3'b101, 60, 1, 70, 192, 0});
    tbl.push_back('{0, 0, 3'b101, 60, 1, 88, 192, 0});
    tbl.push_back('{0, 1, 3'b101, 60, 1, 72, 192, 1});
    tbl.push_back('{0, 2, 3'b101, 60, 1, 72, 192, 0});
    tbl.push_back('{0, 0, 3'b101, 60, 1, 118, 392, 1});
    tbl.push_back('{0, 0, 3'b101, 60, 1, 112, 392, 0});
    tbl.push_back('{0, 0, 3'b101, 60, 1, 238, 392, 0});
    tbl.push_back('{0, 0, 3'b101, 60, 1, 358, 392, 1});
    tbl.push_back('{0, 0, 3'b101, 60, 1, 360, 400, 1});
    tbl.push_back('{0, 0, 3'b101, 60, 1, 356, 400, 0});
    tbl.push_back('{0, 0, 3'b101, 60, 0, 72, 192, 0});
    tbl.push_back('{1, 0, 3'b101, 60, 1, 72, 192, 0});
    tbl.push_back('{1, 0, 3'b101, 60, 1, 74, 192, 1});
    tbl.push_back('{1, 0, 3'b101, 60, 0, 74, 192, 0});
    tbl.push_back('{1, 0, 3'b101, 60, 1, 238, 392, 1});
    tbl.push_back('{0, 0, 3'b001, 2, 1, 0, 400, 0});
    tbl.push_back('{0, 0, 3'b001, 2, 1, 2, 400, 1});
    tbl.push_back('{0, 0, 3'b001, 2, 1, 10, 400, 1});
    tbl.push_back('{0, 0, 3'b001, 2, 1, 12, 400, 0});
    tbl.push_back('{0, 0, 3'b001, 2, 1, 4094, 400, 0});

    foreach (tbl[k]) begin
      dino_y = COORD_W'(100);
      dino_state = 2'(tbl[k].state);
      set_obs(tbl[k].obs0, 120, 180);
      obstacle_en = tbl[k].en;
      night = tbl[k].nt;
      probe($sformatf("table[%0d]", k), tbl[k].vx, tbl[k].vy, tbl[k].d, 1'b1, tbl[k].exp);
    end

    // Clipped obstacle row and the far-right edge of the raster.
    set_obs(2, 120, 180); obstacle_en = 3'b001; night = 0;
    step(0, 0, 0, 1);
    for (int x = 0; x < 24; x++) step(x, 400, 1, 0);
    for (int x = 4072; x < 4096; x++) step(x, 400, 1, 0);

    // Shadowing: a mid-frame move is only seen after the next frame_start.
    set_obs(60, 120, 180); obstacle_en = 3'b001;
    probe("shadow_old_frame_start", 118, 392, 1, 1, 1);
    set_obs(200, 120, 180);
    probe("shadow_still_old", 118, 392, 1, 0, 1);
    probe("shadow_new_not_yet", 398, 392, 1, 0, 0);
    probe("shadow_new_after_fs", 398, 392, 1, 1, 1);
    probe("shadow_old_gone", 118, 392, 1, 0, 0);

    // Collision: obstacle on top of the grounded dino.
    dino_y = COORD_W'(GROUND_SCREEN_Y); dino_state = 2'd0;
    set_obs(DINO_SCREEN_X, 120, 180); obstacle_en = 3'b001;
    step(0, 0, 0, 1);
    for (int y = 192; y < 208; y++)
      for (int x = 32; x < 48; x++) step(2*x, 2*y, 1, 0);
    set_obs(300, 120, 180);
    step(0, 0, 0, 1);
    check("collision_set", int'(collision), 1);
    for (int y = 192; y < 208; y++)
      for (int x = 32; x < 48; x++) step(2*x, 2*y, 1, 0);
    step(0, 0, 0, 1);
    check("collision_clear", int'(collision), 0);
    // Single overlapping pixel still in the compose stage when frame_start arrives.
    set_obs(DINO_SCREEN_X, 120, 180);
    step(2*DINO_SCREEN_X, 2*GROUND_SCREEN_Y, 1, 1);
    check("collision_before_last", int'(collision), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("collision_last_pixel", int'(collision), 1);

    // Randomised stream; game state may change at any time, only frame_start latches it.
    for (int n = 0; n < 3000; n++) begin
      int vx, vy;
      if ($urandom_range(0, 19) == 0) begin
        dino_y = COORD_W'($urandom_range(150, 220));
        dino_state = 2'($urandom_range(0, 3));
        set_obs($urandom_range(0, 300), $urandom_range(0, 300), $urandom_range(0, 300));
        obstacle_en = 3'($urandom_range(0, 7));
        night = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1) == 0) vx = $urandom_range(60, 100);
      else vx = $urandom_range(0, 700);
      vy = $urandom_range(300, 500);
      step(vx, vy, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    // Asynchronous reset in the middle of a frame.
    dino_y = COORD_W'(GROUND_SCREEN_Y);
    set_obs(DINO_SCREEN_X, 120, 180); obstacle_en = 3'b111; night = 1;
    step(0, 0, 0, 1);
    for (int x = 32; x < 48; x++) step(2*x, 2*GROUND_SCREEN_Y, 1, 0);
    step(0, 0, 0, 1);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_pixel", int'(pixel), 0);
    check("midreset_pixel_de", int'(pixel_de), 0);
    check("midreset_collision", int'(collision), 0);
    repeat (5) @(posedge clk);
    #1;
    check("held_reset_pixel", int'(pixel), 0);
    check("held_reset_pixel_de", int'(pixel_de), 0);
    check("held_reset_collision", int'(collision), 0);
    rst_n = 1'b1;
    model_reset();

    // No frame_start yet: a raster over the top of the screen must stay blank.
    dino_y = COORD_W'(4); set_obs(20, 40, 60); obstacle_en = 3'b111; night = 1;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 128; x++) step(x, y, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Parametrised pixel renderer for the dinosaur game, replacing the single-obstacle renderer. It composes one dinosaur sprite and NUM_OBS independently enabled obstacle sprites into a monochrome pixel stream, downsampling VGA coordinates by 2^SCALE_SHIFT. Game-state inputs are shadow-latched once per frame so sprites never tear mid-frame. A per-frame pixel-accurate dino/obstacle collision flag is reported to the game FSM. The block sits between the game-state logic and the VGA timing/output stage.

## Interface
Parameters:
- NUM_OBS, 3, number of obstacle channels (1..8)
- SCALE_SHIFT, 1, downsample shift: screen = vga >> SCALE_SHIFT (0..2)
- COORD_W, 12, coordinate width

Ports:
- pixel_clk  in  1  pixel clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at first pixel of each frame
- de  in  1  display-enable for the current vga_x/vga_y
- vga_x, vga_y  in  COORD_W  current raster position
- dino_y  in  COORD_W  dino vertical centre, screen space
- dino_state  in  2  dino animation frame index (0..3)
- obstacle_x  in  NUM_OBS*COORD_W  packed obstacle horizontal centres; channel i at bits [i*COORD_W +: COORD_W]
- obstacle_en  in  NUM_OBS  per-channel draw enable
- night  in  1  invert colours
- pixel  out  1  lit pixel, registered
- pixel_de  out  1  de delayed to align with pixel
- collision  out  1  previous frame contained a dino/obstacle overlap

## Operation
- Shadow registers: on frame_start, capture dino_y, dino_state, obstacle_x, obstacle_en, night. All rendering uses the shadow copies only.
- Rect test per sprite: pos = centre − BITMAP_CENTER, computed signed in COORD_W+1 bits. Negative pos is legal, giving left/top clipping. Inside when pos ≤ screen < pos+size; compare screen coordinates zero-extended to signed.
- Dino bitmap address = state*SIZE_X*SIZE_Y + rel_y*SIZE_X + rel_x. This uses SIZE_Y, not CENTER_Y.
- Obstacle address = rel_y*SIZE_X + rel_x. Disabled channels contribute 0.
- obs_hit = OR over channels. pixel = de_d ? (night_s XOR (dino_hit OR obs_hit)) : 0.
- Collision accumulator: set when de_d AND dino_hit AND obs_hit.
- On frame_start: collision ← acc OR (hit in stage 3 this cycle), then acc clears.

## Timing
- Three-stage pipeline; latency is 3 cycles from vga_x/vga_y/de to pixel/pixel_de.
  - S1: downsample, rect tests, rel coordinates.
  - S2: address calculation and bitmap lookup.
  - S3: compose and register output.
- frame_start takes effect on the shadow registers at that edge. The first pixel of a frame, entering the pipeline on the same cycle, uses the new shadow values; S1 bypasses to the incoming values when frame_start=1.
- Reset values: pixel=0, pixel_de=0, collision=0, accumulator=0, all shadow registers=0, pipeline valid/de stages=0.
- Reset mid-frame: outputs go to 0 immediately. Nothing is drawn from shadows until the next frame_start; shadow obstacle_en=0 and night=0 guarantee a blank output.
- collision is stable for a whole frame and updates only on the frame_start edge.
- Coordinate arithmetic wraps at COORD_W+1 bits. Sprites entirely right of the screen are simply never inside.

## Structure
- Shared parameters package holds:
  - DINO_SCREEN_X and GROUND_SCREEN_Y
  - DINO_/OBSTACLE_BITMAP_SIZE_X/Y and _CENTER_X/Y
  - DINO_IMG and OBSTACLE_IMG
- One sub-module, sprite_rect: a signed-clipping rect test that registers in_rect, rel_x and rel_y (pipeline stage S1). It is instantiated NUM_OBS+1 times via generate.

## Test plan
- Reset with rst_n=0 mid-frame, then hold for 5 cycles: pixel=0, pixel_de=0, collision=0. After release and before any frame_start, a full raster gives pixel=0 everywhere.
- Latency/alignment, SCALE_SHIFT=1: frame_start with dino_y=100 and de=1, then raster vga=(2*(DINO_SCREEN_X−CX), 2*(100−CY)). pixel equals DINO_IMG[state*SX*SY] exactly 3 cycles later.
- Clipping: obstacle_x[0]=2 (less than OBSTACLE center X). Visible columns 0..(2−CX+SX−1) match the right part of the bitmap, and no wrapped pixels appear near x=4095/2.
- Enable/channels, NUM_OBS=3: channels at x=60, 120, 180 with en=3'b101. Sprites are drawn at 60 and 180 and nothing at 120. With night=1 the output is inverted, but only while de=1.
- Shadowing: change obstacle_x from 60 to 200 mid-frame. The current frame still draws at 60; after the next frame_start the sprite draws at 200.
- Collision: set obstacle_x[0]=DINO_SCREEN_X with dino_y=GROUND_SCREEN_Y. collision=1 after the next frame_start and 0 after the following frame once the obstacle is moved to 300. Also cover an overlap on the last pixel coinciding with frame_start, which must still set collision.
